matrix_dot_sequencer: RTL and testbench

- Upstream/control stage for the combinational multiply-accumulate element (8b x 8b product plus 16b running sum, yielding a 16b new sum and a carry-out).
- Accepts a stream of operand pairs over a valid/ready handshake and drives the MAC's entry and sum inputs from an internal accumulator register.
- Captures the MAC result each accepted beat. After LEN pairs, presents one 16b dot-product element on a valid/ready output.
- Sits between the matrix operand fetch logic and the result write-back.

---
 rtl/matrix_dot_sequencer.sv | 109 ++++++++++
 tb/tb_matrix_dot_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_dot_sequencer.sv
// Purpose : sequences LEN operand pairs through an external combinational MAC and
//           holds the dot-product result until the consumer takes it.
// Latency : out_valid rises the cycle after the LEN-th accepted pair; one result per LEN+1 cycles at best.
// Backpressure: in_ready is low while a result waits; the result holds stable until out_ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready, in_a/in_b operand pair handshake (8b row and column entries)
//   mac_entry1/2, mac_sum       operands and running sum driven to the MAC
//   mac_new_sum, mac_c15        MAC result and carry-out of its 16b add
//   out_valid/out_ready         result handshake
//   out_sum, out_ovf            16b dot product and sticky carry-out flag
//
// Optional build macro MATRIX_DOT_SATURATE_EN: a carry-out clamps the
// accumulator to 16'hFFFF for the rest of the vector instead of wrapping.

module matrix_dot_sequencer #(
    parameter int LEN   = 4,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  mac_entry1,
    output logic [7:0]  mac_entry2,
    output logic [15:0] mac_sum,
    input  logic [15:0] mac_new_sum,
    input  logic        mac_c15,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    // The MAC is purely combinational: operands pass straight through and the
    // running sum comes from the accumulator register.
    assign mac_entry1 = in_a;
    assign mac_entry2 = in_b;
    assign mac_sum    = acc_q;
    assign out_sum    = acc_q;
    assign out_ovf    = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= 16'd0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ovf_d = ovf_q | mac_c15;
`ifdef MATRIX_DOT_SATURATE_EN
                    // Once any beat has carried out, the sum is pinned at full scale.
                    acc_d = (ovf_q | mac_c15) ? 16'hFFFF : mac_new_sum;
`else
                    acc_d = mac_new_sum;
`endif
                    if (cnt_q == CNT_W'(LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Pending input pairs are left waiting upstream; only the drain matters here.
                if (out_ready) begin
                    acc_d   = 16'd0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_dot_sequencer.sv
module tb_matrix_dot_sequencer;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (LEN=4)
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf, mac_c15;
    logic [7:0]  in_a, in_b, mac_entry1, mac_entry2;
    logic [15:0] mac_sum, mac_new_sum, out_sum, prod;
    logic [16:0] mac_full;

    // Combinational MAC the sequencer drives
    assign prod     = {8'd0, mac_entry1} * {8'd0, mac_entry2};
    assign mac_full = {1'b0, mac_sum} + {1'b0, prod};
    assign mac_new_sum = mac_full[15:0];
    assign mac_c15     = mac_full[16];

    matrix_dot_sequencer #(.LEN(LEN), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_entry1(mac_entry1), .mac_entry2(mac_entry2), .mac_sum(mac_sum),
        .mac_new_sum(mac_new_sum), .mac_c15(mac_c15),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    // Second DUT (LEN=1)
    logic        u1_in_valid, u1_in_ready, u1_out_valid, u1_out_ready, u1_out_ovf, u1_c15;
    logic [7:0]  u1_in_a, u1_in_b, u1_e1, u1_e2;
    logic [15:0] u1_mac_sum, u1_new_sum, u1_out_sum, u1_prod;
    logic [16:0] u1_full;

    assign u1_prod    = {8'd0, u1_e1} * {8'd0, u1_e2};
    assign u1_full    = {1'b0, u1_mac_sum} + {1'b0, u1_prod};
    assign u1_new_sum = u1_full[15:0];
    assign u1_c15     = u1_full[16];

    matrix_dot_sequencer #(.LEN(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u1_in_valid), .in_ready(u1_in_ready), .in_a(u1_in_a), .in_b(u1_in_b),
        .mac_entry1(u1_e1), .mac_entry2(u1_e2), .mac_sum(u1_mac_sum),
        .mac_new_sum(u1_new_sum), .mac_c15(u1_c15),
        .out_valid(u1_out_valid), .out_ready(u1_out_ready),
        .out_sum(u1_out_sum), .out_ovf(u1_out_ovf)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  va [LEN];
    logic [7:0]  vb [LEN];
    logic [15:0] got_sum;
    logic        got_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: dot product computed exactly, then reduced to 16 bits by the chosen policy.
    function automatic int exp_sum(input int t);
`ifdef MATRIX_DOT_SATURATE_EN
        return (t > 65535) ? 65535 : t;
`else
        return t % 65536;
`endif
    endfunction

    // Sends va/vb as one vector with gap_min..gap_max idle cycles between beats,
    // holds out_ready low for bp cycles, then drains the result.
    task automatic run_vec(input string tag, input int gap_min, input int gap_max, input int bp);
        int pre;
        int g;
        pre = 0;
        for (int i = 0; i < LEN; i++) begin
            @(negedge clk);
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_mac_sum"}, 32'(mac_sum), 32'(exp_sum(pre)));
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            #1;
            check({tag, "_entry1"}, 32'(mac_entry1), 32'(va[i]));
            check({tag, "_entry2"}, 32'(mac_entry2), 32'(vb[i]));
            @(posedge clk);
            pre = pre + int'(va[i]) * int'(vb[i]);
            if (i < LEN - 1) begin
                g = int'($urandom_range(gap_max, gap_min));
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_a = 8'($urandom);
                    in_b = 8'($urandom);
                    #1;
                    check({tag, "_idle_entry1"}, 32'(mac_entry1), 32'(in_a));
                    check({tag, "_idle_hold"}, 32'(mac_sum), 32'(exp_sum(pre)));
                    check({tag, "_idle_no_out"}, 32'(out_valid), 32'd0);
                    @(posedge clk);
                end
            end
        end
        @(negedge clk);
        // Offer a stray pair while the result is pending; it must be ignored.
        in_valid = 1'b1;
        in_a = 8'($urandom_range(255, 1));
        in_b = 8'($urandom_range(255, 1));
        got_sum = out_sum;
        got_ovf = out_ovf;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        check({tag, "_out_sum"}, 32'(out_sum), 32'(exp_sum(pre)));
        check({tag, "_out_ovf"}, 32'(out_ovf), 32'(pre > 65535));
        repeat (bp) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_bp_sum"}, 32'(out_sum), 32'(exp_sum(pre)));
            check({tag, "_bp_ovf"}, 32'(out_ovf), 32'(pre > 65535));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_drain_acc"}, 32'(mac_sum), 32'd0);
        check({tag, "_drain_ovf"}, 32'(out_ovf), 32'd0);
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(posedge clk);
    endtask

    initial begin
        int exp_big;
        int p;
        in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; out_ready = 1'b0;
        u1_in_valid = 1'b0; u1_in_a = 8'd0; u1_in_b = 8'd0; u1_out_ready = 1'b0;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_mac_sum", 32'(mac_sum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed vector
        va = '{8'd8, 8'd8, 8'd2, 8'd7};
        vb = '{8'd8, 8'd8, 8'd4, 8'd3};
        run_vec("v1", 0, 0, 1);
        check("v1_tp157", 32'(got_sum), 32'd157);
        check("v1_tp_ovf", 32'(got_ovf), 32'd0);

        // Same vector with valid toggling between beats
        run_vec("v2", 1, 1, 1);
        check("v2_tp157", 32'(got_sum), 32'd157);

        // Overflowing vector with 3 cycles of backpressure
        va = '{8'd255, 8'd255, 8'd0, 8'd0};
        vb = '{8'd255, 8'd255, 8'd0, 8'd0};
        run_vec("v3", 0, 0, 3);
`ifdef MATRIX_DOT_SATURATE_EN
        exp_big = 65535;
`else
        exp_big = 64514;
`endif
        check("v3_tp_sum", 32'(got_sum), 32'(exp_big));
        check("v3_tp_ovf", 32'(got_ovf), 32'd1);

        va = '{8'd1, 8'd1, 8'd1, 8'd1};
        vb = '{8'd1, 8'd1, 8'd1, 8'd1};
        run_vec("v4", 0, 0, 0);
        check("v4_tp4", 32'(got_sum), 32'd4);

        // Reset after two accepted beats
        beat(8'd200, 8'd200);
        beat(8'd250, 8'd250);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_mac_sum", 32'(mac_sum), 32'd0);
        check("rst_mid_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        va = '{8'd3, 8'd10, 8'd100, 8'd9};
        vb = '{8'd5, 8'd20, 8'd100, 8'd9};
        run_vec("v5", 0, 1, 1);
        check("v5_tp_sum", 32'(got_sum), 32'd10296);

        // Reset while a result is pending
        for (int i = 0; i < LEN; i++) beat(8'd255, 8'd255);
        @(negedge clk);
        in_valid = 1'b0;
        check("done_before_rst", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_done_valid", 32'(out_valid), 32'd0);
        check("rst_done_sum", 32'(out_sum), 32'd0);
        check("rst_done_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized vectors, mixing small and full-range operands
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < LEN; i++) begin
                if (n % 2 == 0) begin
                    va[i] = 8'($urandom_range(255, 0));
                    vb[i] = 8'($urandom_range(255, 0));
                end else begin
                    va[i] = 8'($urandom_range(40, 0));
                    vb[i] = 8'($urandom_range(40, 0));
                end
            end
            run_vec("rnd", 0, 2, int'($urandom_range(3, 0)));
        end

        // LEN=1 instance: every accept goes straight to DONE
        u1_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("u1_in_ready", 32'(u1_in_ready), 32'd1);
            check("u1_idle_valid", 32'(u1_out_valid), 32'd0);
            u1_in_valid = 1'b1;
            u1_in_a = (k == 0) ? 8'd12 : 8'($urandom);
            u1_in_b = (k == 0) ? 8'd10 : 8'($urandom);
            p = int'(u1_in_a) * int'(u1_in_b);
            @(posedge clk);
            @(negedge clk);
            check("u1_out_valid", 32'(u1_out_valid), 32'd1);
            check("u1_in_ready_done", 32'(u1_in_ready), 32'd0);
            check("u1_out_sum", 32'(u1_out_sum), 32'(p));
            check("u1_out_ovf", 32'(u1_out_ovf), 32'd0);
            if (k == 0) check("u1_tp120", 32'(u1_out_sum), 32'd120);
            @(posedge clk);
        end
        @(negedge clk);
        u1_in_valid = 1'b0;
        u1_out_ready = 1'b0;
        check("u1_final_ready", 32'(u1_in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
